// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//
// Stands in for a physical 4x4 matrix keypad on the far side of the scanner's
// column/row interface. A press is requested with a 4-bit key code and played
// out as press bounce, steady hold and release bounce. While the key is
// electrically closed, the key's row line follows its column drive line,
// exactly as a real switch closure would.
//
// Build option:
//   KEYPAD_EMU_BOUNCE_EN  defined   : bounce phases are generated from an 8-bit
//                                     LFSR (IDLE->BOUNCE_IN->HOLD->BOUNCE_OUT).
//                         undefined : clean contact, IDLE->HOLD->IDLE, no LFSR.
//
// Parameters:
//   BOUNCE_CYCLES  length of each bounce phase in clk cycles (>= 1)
//   HOLD_CYCLES    length of the steady-closed phase in clk cycles (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   columnas   in   [3:0] column drive (bit3 = column 0 ... bit0 = column 3)
//   key_code   in   [3:0] key to press, sampled only on an accepted press_req
//   press_req  in   request a press; accepted only while idle
//   busy       out  high while a press sequence is in progress
//   done       out  one-cycle pulse when a press sequence completes
//   filas      out  [3:0] row lines, active-high (bit3 = row 0 ... bit0 = row 3)
// -----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 2200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columnas,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic       busy,
    output logic       done,
    output logic [3:0] filas
);

    localparam int MAX_LEN = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd2;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [1:0] BOUNCE_IN  = 2'd1;
    localparam logic [1:0] BOUNCE_OUT = 2'd3;
    localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
`endif

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [3:0]    col_mask_reg;
    logic [3:0]    row_mask_reg;
    logic [3:0]    col_dec;
    logic [3:0]    row_dec;
    logic          load;
    logic          done_reg;
    logic          done_next;
    logic [3:0]    filas_reg;
    logic [3:0]    filas_next;
    logic          contact;
    logic          col_hit;

    // ------------------------------------------------------------------
    // Key code to one-hot column/row masks, laid out as the scanner
    // decodes them:  row0: 1 2 3 A   row1: 4 5 6 B
    //                row2: 7 8 9 C   row3: D 0 E F
    // Column c drives columnas[3-c]; row r drives filas[3-r].
    // ------------------------------------------------------------------
    always_comb begin
        col_dec = 4'b0000;
        row_dec = 4'b0000;
        case (key_code)
            4'h1: begin col_dec = 4'b1000; row_dec = 4'b1000; end
            4'h2: begin col_dec = 4'b0100; row_dec = 4'b1000; end
            4'h3: begin col_dec = 4'b0010; row_dec = 4'b1000; end
            4'hA: begin col_dec = 4'b0001; row_dec = 4'b1000; end
            4'h4: begin col_dec = 4'b1000; row_dec = 4'b0100; end
            4'h5: begin col_dec = 4'b0100; row_dec = 4'b0100; end
            4'h6: begin col_dec = 4'b0010; row_dec = 4'b0100; end
            4'hB: begin col_dec = 4'b0001; row_dec = 4'b0100; end
            4'h7: begin col_dec = 4'b1000; row_dec = 4'b0010; end
            4'h8: begin col_dec = 4'b0100; row_dec = 4'b0010; end
            4'h9: begin col_dec = 4'b0010; row_dec = 4'b0010; end
            4'hC: begin col_dec = 4'b0001; row_dec = 4'b0010; end
            4'hD: begin col_dec = 4'b1000; row_dec = 4'b0001; end
            4'h0: begin col_dec = 4'b0100; row_dec = 4'b0001; end
            4'hE: begin col_dec = 4'b0010; row_dec = 4'b0001; end
            4'hF: begin col_dec = 4'b0001; row_dec = 4'b0001; end
            default: begin col_dec = 4'b0000; row_dec = 4'b0000; end
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Bounce source: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running in
    // every state so each press sees a different bounce pattern.
    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Phase FSM. The counter restarts at zero on every state entry and
    // the state is left when it reaches its phase length minus one.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg + 1'b1;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (press_req) begin
                    load = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_next = BOUNCE_IN;
`else
                    state_next = HOLD;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE_IN: begin
                if (count_reg == BOUNCE_LAST) begin
                    state_next = HOLD;
                    count_next = '0;
                end
            end
            HOLD: begin
                if (count_reg == HOLD_LAST) begin
                    state_next = BOUNCE_OUT;
                    count_next = '0;
                end
            end
            BOUNCE_OUT: begin
                if (count_reg == BOUNCE_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                    done_next  = 1'b1;
                end
            end
`else
            HOLD: begin
                if (count_reg == HOLD_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                    done_next  = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Electrical state of the switch for the current cycle.
    always_comb begin
        contact = 1'b0;
        case (state_reg)
            HOLD: contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE_IN, BOUNCE_OUT: contact = lfsr_reg[0];
`endif
            default: contact = 1'b0;
        endcase
    end

    // A closed key connects its column to its row: any driven column that
    // overlaps the key's column (multi-hot drive included) lights its row.
    assign col_hit = |(columnas & col_mask_reg);

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign filas_next[gi] = contact & col_hit & row_mask_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            col_mask_reg <= 4'b0000;
            row_mask_reg <= 4'b0000;
            done_reg     <= 1'b0;
            filas_reg    <= 4'b0000;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            filas_reg <= filas_next;
            if (load) begin
                col_mask_reg <= col_dec;
                row_mask_reg <= row_dec;
            end
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign filas = filas_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
//
// Self-checking bench for keypad_emulator with BOUNCE_CYCLES=8, HOLD_CYCLES=32.
// Works with KEYPAD_EMU_BOUNCE_EN either defined or undefined; expectations
// follow whichever build is compiled. The reference model tracks each press
// as "cycles elapsed since acceptance" and derives busy/done/filas from the
// phase windows; during bounce windows filas may only be 0 or the key's row.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int B = 8;
    localparam int H = 32;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int TOTAL = 2 * B + H;
    localparam int S0    = B + 1;
`else
    localparam int TOTAL = H;
    localparam int S0    = 1;
`endif
    localparam int S1 = S0 + H - 1;

    logic       clk;
    logic       reset;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       press_req;
    logic       busy;
    logic       done;
    logic [3:0] filas;

    keypad_emulator #(
        .BOUNCE_CYCLES(B),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .columnas (columnas),
        .key_code (key_code),
        .press_req(press_req),
        .busy     (busy),
        .done     (done),
        .filas    (filas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // Physical keypad layout, row-major: index = row*4 + column.
    logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hD, 4'h0, 4'hE, 4'hF};

    function automatic int pos_of(input logic [3:0] code);
        for (int i = 0; i < 16; i++)
            if (layout[i] == code) return i;
        return 0;
    endfunction

    function automatic logic [3:0] col_line(input logic [3:0] code);
        logic [3:0] one = 4'b1000;
        return one >> (pos_of(code) % 4);
    endfunction

    function automatic logic [3:0] row_line(input logic [3:0] code);
        logic [3:0] one = 4'b1000;
        return one >> (pos_of(code) / 4);
    endfunction

    // Model state: expectations for the upcoming cycle.
    int         m_rel   = 0;     // 0 = idle, 1..TOTAL = cycles since acceptance
    logic       m_done  = 1'b0;
    logic [3:0] m_filas = 4'b0;
    logic       m_loose = 1'b0;  // bounce: filas may be 0 or m_filas
    logic [3:0] m_key   = 4'h0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_idle();
        m_rel   = 0;
        m_done  = 1'b0;
        m_filas = 4'b0;
        m_loose = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic cyc(input logic preq, input logic [3:0] key, input logic [3:0] cols);
        int         cls;
        logic [3:0] pat;
        @(posedge clk);
        #1;
        press_req = preq;
        key_code  = key;
        columnas  = cols;
        cyc_no++;
        @(negedge clk);
        chk("busy", {3'b0, busy}, {3'b0, (m_rel >= 1 && m_rel <= TOTAL)});
        chk("done", {3'b0, done}, {3'b0, m_done});
        if (m_loose) begin
            checks++;
            if ((filas & ~m_filas) != 4'b0) begin
                errors++;
                $display("FAIL filas_bounce cycle %0d got %b allowed 0000 or %b", cyc_no, filas, m_filas);
            end
        end else begin
            chk("filas", filas, m_filas);
        end
        // contact class this cycle: 0 open, 1 closed, 2 bouncing
        if (m_rel == 0) cls = 0;
        else if (m_rel >= S0 && m_rel <= S1) cls = 1;
        else cls = 2;
        pat     = ((cols & col_line(m_key)) != 4'b0) ? row_line(m_key) : 4'b0;
        m_filas = (cls == 0) ? 4'b0 : pat;
        m_loose = (cls == 2);
        if (m_rel == 0) begin
            m_done = 1'b0;
            if (preq) begin
                m_rel = 1;
                m_key = key;
                $display("press key %h accepted at cycle %0d", key, cyc_no);
            end
        end else if (m_rel == TOTAL) begin
            m_rel  = 0;
            m_done = 1'b1;
        end else begin
            m_rel++;
            m_done = 1'b0;
        end
    endtask

    task automatic drain(input logic [3:0] cols);
        while (m_rel != 0) cyc(1'b0, 4'($urandom), cols);
        cyc(1'b0, 4'($urandom), cols);  // done cycle
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        press_req = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", {3'b0, busy}, 4'b0);
        chk("done_after_reset", {3'b0, done}, 4'b0);
        model_idle();
    endtask

    typedef struct {
        logic [3:0] key;
        logic [3:0] cols;
        logic [3:0] exp_filas;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         busy_cnt;
        int         done_at;
        int         done_cnt;
        logic [3:0] k;
        logic [3:0] c;

        tbl[0]  = '{4'h5, 4'b0100, 4'b0100};
        tbl[1]  = '{4'h5, 4'b1000, 4'b0000};
        tbl[2]  = '{4'hA, 4'b0001, 4'b1000};
        tbl[3]  = '{4'h0, 4'b0100, 4'b0001};
        tbl[4]  = '{4'h1, 4'b1000, 4'b1000};
        tbl[5]  = '{4'hF, 4'b0001, 4'b0001};
        tbl[6]  = '{4'hD, 4'b1000, 4'b0001};
        tbl[7]  = '{4'h7, 4'b1000, 4'b0010};
        tbl[8]  = '{4'hC, 4'b0001, 4'b0010};
        tbl[9]  = '{4'h3, 4'b1111, 4'b1000};
        tbl[10] = '{4'h9, 4'b1101, 4'b0000};
        tbl[11] = '{4'hB, 4'b0011, 4'b0100};
        tbl[12] = '{4'hE, 4'b0010, 4'b0001};

        // Reset held with press_req high: nothing may happen.
        reset     = 1'b1;
        press_req = 1'b1;
        key_code  = 4'h5;
        columnas  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_filas", filas, 4'b0);
            chk("reset_busy", {3'b0, busy}, 4'b0);
            chk("reset_done", {3'b0, done}, 4'b0);
        end
        reset_release();
        cyc(1'b0, 4'h0, 4'b0);

        // Table: mapping checked mid-hold, key_code scrambled while busy.
        for (int t = 0; t < 13; t++) begin
            cyc(1'b1, tbl[t].key, 4'b0);
            while (m_rel != S0 + 3) cyc(1'b0, 4'($urandom), 4'b0);
            cyc(1'b0, 4'($urandom), tbl[t].cols);
            cyc(1'b0, 4'($urandom), tbl[t].cols);
            chk("map_table", filas, tbl[t].exp_filas);
            $display("vector %0d key %h cols %b filas %b", t, tbl[t].key, tbl[t].cols, filas);
            drain(4'b0);
        end

        // Sequence timing and back-to-back press in the done cycle.
        cyc(1'b1, 4'h5, 4'b0100);
        busy_cnt = 0;
        done_at  = -1;
        for (int i = 1; i <= TOTAL + 1; i++) begin
            cyc(i == TOTAL + 1, 4'h2, 4'b0100);
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = i;
        end
        chk("busy_len", 4'(busy_cnt), 4'(TOTAL));
        checks++;
        if (done_at != TOTAL + 1) begin
            errors++;
            $display("FAIL done_cycle got %0d expected %0d", done_at, TOTAL + 1);
        end
        cyc(1'b0, 4'h0, 4'b0100);
        chk("back_to_back_busy", {3'b0, busy}, 4'b0001);
        $display("timing: busy %0d cycles, done at %0d", busy_cnt, done_at);
        drain(4'b0);

        // press_req ignored while busy: key 7 sequence, key 3 requested at 20.
        cyc(1'b1, 4'h7, 4'b1010);
        done_cnt = 0;
        for (int i = 1; i <= TOTAL + 3; i++) begin
            cyc(i == 20, (i == 20) ? 4'h3 : 4'($urandom), 4'b1010);
            if (done) done_cnt++;
            if (i >= S0 + 1 && i <= S1 + 1) chk("ignore_row2", filas, 4'b0010);
        end
        chk("ignore_done_cnt", 4'(done_cnt), 4'd1);

        // Reset in the middle of HOLD: outputs clear within the same cycle.
        cyc(1'b1, 4'h5, 4'b0100);
        while (m_rel != 30) cyc(1'b0, 4'h5, 4'b0100);
        cyc(1'b0, 4'h5, 4'b0100);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_filas", filas, 4'b0);
        chk("midreset_busy", {3'b0, busy}, 4'b0);
        chk("midreset_done", {3'b0, done}, 4'b0);
        @(negedge clk);
        chk("midreset_done_hold", {3'b0, done}, 4'b0);
        reset_release();
        for (int i = 0; i < TOTAL; i++) cyc(1'b0, 4'h5, 4'b0100);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            k = 4'($urandom);
            if ($urandom_range(0, 1) == 0) c = 4'b0001 << $urandom_range(0, 3);
            else c = 4'($urandom);
            cyc($urandom_range(0, 15) == 0, k, c);
        end
        drain(4'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
